// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and shared-memory signals around mem_arbiter.
// The arbiter takes the slave view; the requesters and memory take the master view.
interface mem_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ack;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;
    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    logic              busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        output i_rdata, i_ack, d_rdata, d_ack, m_en, m_we, m_addr, m_wdata, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  i_rdata, i_ack, d_rdata, d_ack, m_en, m_we, m_addr, m_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises fetch and data accesses onto one single-port memory, data first with fetch anti-starvation.
// Define MEMARB_PERF_EN to add saturating grant/conflict counters.
module mem_arbiter #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 8,
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 2
) (
    input  logic         clock,
    input  logic         reset,
    mem_arbiter_if.slave bus
`ifdef MEMARB_PERF_EN
    ,
    output logic [15:0]  i_grant_cnt,
    output logic [15:0]  d_grant_cnt,
    output logic [15:0]  conflict_cnt
`endif
);
    localparam int LAT_W    = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
    localparam int STARVE_W = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;
    typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_I = 2'd1, OWN_D = 2'd2} owner_t;

    state_t              state_r;
    owner_t              owner_r;
    logic                we_r;
    logic [LAT_W-1:0]    lat_cnt_r;
    logic [STARVE_W-1:0] starve_r;
    logic                starved_s;
    logic                grant_i_s;
    logic                grant_d_s;

    // Arbitration decision for the current IDLE cycle
    always_comb begin
        starved_s = (starve_r >= STARVE_W'(STARVE_LIMIT));
        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
        if (bus.i_req && bus.d_req) begin
            grant_i_s = starved_s;
            grant_d_s = !starved_s;
        end else begin
            grant_i_s = bus.i_req;
            grant_d_s = bus.d_req;
        end
    end

    // Access sequencer: IDLE -> ISSUE -> (WAIT) -> DONE, all outputs registered
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= IDLE;
            owner_r     <= OWN_NONE;
            we_r        <= 1'b0;
            lat_cnt_r   <= LAT_W'(0);
            starve_r    <= STARVE_W'(0);
            bus.m_en    <= 1'b0;
            bus.m_we    <= 1'b0;
            bus.m_addr  <= ADDR_W'(0);
            bus.m_wdata <= DATA_W'(0);
            bus.i_rdata <= DATA_W'(0);
            bus.d_rdata <= DATA_W'(0);
            bus.i_ack   <= 1'b0;
            bus.d_ack   <= 1'b0;
            bus.busy    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    bus.i_ack <= 1'b0;
                    bus.d_ack <= 1'b0;
                    if (grant_d_s) begin
                        owner_r     <= OWN_D;
                        we_r        <= bus.d_we;
                        bus.m_en    <= 1'b1;
                        bus.m_we    <= bus.d_we;
                        bus.m_addr  <= bus.d_addr;
                        bus.m_wdata <= bus.d_wdata;
                        bus.busy    <= 1'b1;
                        state_r     <= ISSUE;
                        // fetch lost this round: count towards forcing it through
                        if (bus.i_req && !starved_s) begin
                            starve_r <= starve_r + STARVE_W'(1);
                        end else begin
                            starve_r <= starve_r;
                        end
                    end else if (grant_i_s) begin
                        owner_r     <= OWN_I;
                        we_r        <= 1'b0;
                        bus.m_en    <= 1'b1;
                        bus.m_we    <= 1'b0;
                        bus.m_addr  <= bus.i_addr;
                        bus.m_wdata <= DATA_W'(0);
                        bus.busy    <= 1'b1;
                        starve_r    <= STARVE_W'(0);
                        state_r     <= ISSUE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    bus.m_en <= 1'b0;
                    bus.m_we <= 1'b0;
                    if (we_r) begin
                        bus.d_ack <= (owner_r == OWN_D);
                        bus.i_ack <= (owner_r == OWN_I);
                        state_r   <= DONE;
                    end else begin
                        lat_cnt_r <= LAT_W'(MEM_LAT);
                        state_r   <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt_r == LAT_W'(1)) begin
                        if (owner_r == OWN_D) begin
                            bus.d_rdata <= bus.m_rdata;
                        end else begin
                            bus.i_rdata <= bus.m_rdata;
                        end
                        bus.d_ack <= (owner_r == OWN_D);
                        bus.i_ack <= (owner_r == OWN_I);
                        state_r   <= DONE;
                    end else begin
                        lat_cnt_r <= lat_cnt_r - LAT_W'(1);
                    end
                end
                DONE: begin
                    bus.i_ack <= 1'b0;
                    bus.d_ack <= 1'b0;
                    bus.busy  <= 1'b0;
                    owner_r   <= OWN_NONE;
                    state_r   <= IDLE;
                end
                default: begin
                    bus.m_en  <= 1'b0;
                    bus.m_we  <= 1'b0;
                    bus.i_ack <= 1'b0;
                    bus.d_ack <= 1'b0;
                    bus.busy  <= 1'b0;
                    owner_r   <= OWN_NONE;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

`ifdef MEMARB_PERF_EN
    // Saturating grant and conflict counters, sampled only in IDLE
    always_ff @(posedge clock) begin
        if (reset) begin
            i_grant_cnt  <= 16'd0;
            d_grant_cnt  <= 16'd0;
            conflict_cnt <= 16'd0;
        end else if (state_r == IDLE) begin
            if (grant_i_s && (i_grant_cnt != 16'hFFFF)) begin
                i_grant_cnt <= i_grant_cnt + 16'd1;
            end
            if (grant_d_s && (d_grant_cnt != 16'hFFFF)) begin
                d_grant_cnt <= d_grant_cnt + 16'd1;
            end
            if (bus.i_req && bus.d_req && (conflict_cnt != 16'hFFFF)) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
        end else begin
            conflict_cnt <= conflict_cnt;
        end
    end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter: MEM_LAT=1 instance with a behavioural
// memory and reference model, plus a MEM_LAT=3 instance for reset during a pending read.
module tb_mem_arbiter;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int SL = 2;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;
    logic rst3;
    logic load1;

    mem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) b1();
    mem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) b3();

`ifdef MEMARB_PERF_EN
    logic [15:0] ig1, dg1, cf1, ig3, dg3, cf3;
`endif

    mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(1), .STARVE_LIMIT(SL)) dut1 (
        .clock(clock), .reset(reset), .bus(b1)
`ifdef MEMARB_PERF_EN
        , .i_grant_cnt(ig1), .d_grant_cnt(dg1), .conflict_cnt(cf1)
`endif
    );

    mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(3), .STARVE_LIMIT(SL)) dut3 (
        .clock(clock), .reset(rst3), .bus(b3)
`ifdef MEMARB_PERF_EN
        , .i_grant_cnt(ig3), .d_grant_cnt(dg3), .conflict_cnt(cf3)
`endif
    );

    function automatic logic [15:0] seed_word(input logic [7:0] a);
        if (a == 8'h00) return 16'h13ab;
        return {a ^ 8'h5c, ~a};
    endfunction

    // single-port memory with 1-cycle read latency behind dut1
    logic [DW-1:0] mem1 [256];
    logic [DW-1:0] rd1;
    always @(posedge clock) begin
        if (load1) begin
            for (int k = 0; k < 256; k++) mem1[k] <= seed_word(8'(k));
        end else if (b1.m_en) begin
            if (b1.m_we) mem1[b1.m_addr] <= b1.m_wdata;
            else         rd1 <= mem1[b1.m_addr];
        end
    end
    assign b1.m_rdata = rd1;

    // read-only pattern memory with 3-cycle latency behind dut3
    logic [DW-1:0] p1, p2, p3;
    always @(posedge clock) begin
        if (b3.m_en && !b3.m_we) p1 <= {8'hc3, b3.m_addr};
        p2 <= p1;
        p3 <= p2;
    end
    assign b3.m_rdata = p3;

    // reference model state
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] exp_i, exp_d;
    int starve;
    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic run_round(input bit want_i, input bit want_d, input bit hold,
                             input int n_grants, output logic [7:0] order);
        bit pend_i, pend_d, owner_d;
        int got, guard;
        pend_i = want_i; pend_d = want_d; owner_d = 1'b0;
        got = 0; guard = 0; order = 8'h00;
        b1.i_req = want_i;
        b1.d_req = want_d;
        while (got < n_grants && guard < 80) begin
            @(negedge clock);
            guard++;
            if (b1.m_en) begin
                owner_d = (pend_i && pend_d) ? (starve < SL) : pend_d;
                if (!owner_d) starve = 0;
                else if (pend_i && starve < SL) starve++;
                chk("grant_we", 32'(b1.m_we), 32'(owner_d & b1.d_we));
                chk("grant_addr", 32'(b1.m_addr), 32'(owner_d ? b1.d_addr : b1.i_addr));
                if (owner_d && b1.d_we) begin
                    chk("grant_wdata", 32'(b1.m_wdata), 32'(b1.d_wdata));
                    ref_mem[b1.d_addr] = b1.d_wdata;
                end
            end
            if (b1.i_ack || b1.d_ack) begin
                chk("ack_owner", 32'({b1.i_ack, b1.d_ack}), owner_d ? 32'd1 : 32'd2);
                if (!owner_d) exp_i = ref_mem[b1.i_addr];
                else if (!b1.d_we) exp_d = ref_mem[b1.d_addr];
                chk("rdata", {b1.i_rdata, b1.d_rdata}, {exp_i, exp_d});
                order = {order[6:0], b1.d_ack};
                got++;
                if (got == n_grants) begin
                    b1.i_req = 1'b0;
                    b1.d_req = 1'b0;
                end else if (!hold) begin
                    if (owner_d) begin pend_d = 1'b0; b1.d_req = 1'b0; end
                    else         begin pend_i = 1'b0; b1.i_req = 1'b0; end
                end
            end
        end
        if (got < n_grants) chk("round_timeout", 32'(got), 32'(n_grants));
        b1.i_req = 1'b0;
        b1.d_req = 1'b0;
    endtask

    initial begin
        logic [7:0] ord;
        int pat, ng, guard, acks;
        bit hold;

        reset = 1'b1; rst3 = 1'b1; load1 = 1'b1;
        b1.i_req = 1'b0; b1.i_addr = 8'h00; b1.d_req = 1'b0; b1.d_we = 1'b0;
        b1.d_addr = 8'h00; b1.d_wdata = 16'h0000;
        b3.i_req = 1'b0; b3.i_addr = 8'h00; b3.d_req = 1'b0; b3.d_we = 1'b0;
        b3.d_addr = 8'h00; b3.d_wdata = 16'h0000;
        for (int k = 0; k < 256; k++) ref_mem[k] = seed_word(8'(k));
        exp_i = 16'h0000; exp_d = 16'h0000; starve = 0;
        repeat (3) @(negedge clock);
        reset = 1'b0; rst3 = 1'b0; load1 = 1'b0;

        // reset then idle
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            chk("idle_ctl", 32'({b1.m_en, b1.m_we, b1.i_ack, b1.d_ack, b1.busy}), 32'd0);
            chk("idle_bus", 32'({b1.m_addr, b1.m_wdata}), 32'd0);
            chk("idle_rdata", {b1.i_rdata, b1.d_rdata}, 32'd0);
        end

        // fetch read of address 0
        b1.i_addr = 8'h00; b1.i_req = 1'b1;
        @(negedge clock);
        chk("fetch_c1_en_we", 32'({b1.m_en, b1.m_we, b1.busy}), 32'd5);
        chk("fetch_c1_addr", 32'(b1.m_addr), 32'h00);
        @(negedge clock);
        chk("fetch_c2", 32'({b1.m_en, b1.i_ack}), 32'd0);
        @(negedge clock);
        chk("fetch_c3_ack", 32'({b1.i_ack, b1.d_ack}), 32'd2);
        chk("fetch_rdata", 32'(b1.i_rdata), 32'h13ab);
        b1.i_req = 1'b0;
        exp_i = 16'h13ab;

        // data write, then immediate read of the same address
        @(negedge clock);
        b1.d_we = 1'b1; b1.d_addr = 8'h10; b1.d_wdata = 16'h8001; b1.d_req = 1'b1;
        @(negedge clock);
        chk("wr_c1", 32'({b1.m_en, b1.m_we}), 32'd3);
        chk("wr_c1_bus", 32'({b1.m_addr, b1.m_wdata}), 32'h108001);
        b1.d_addr = 8'hee; b1.d_wdata = 16'hdead;
        @(negedge clock);
        chk("wr_c2_ack", 32'({b1.i_ack, b1.d_ack, b1.m_en}), 32'd2);
        ref_mem[8'h10] = 16'h8001;
        b1.d_we = 1'b0; b1.d_addr = 8'h10;
        @(negedge clock);
        chk("rd_gap_no_en", 32'(b1.m_en), 32'd0);
        @(negedge clock);
        chk("rd_en", 32'({b1.m_en, b1.m_we, b1.m_addr}), 32'h210);
        @(negedge clock);
        @(negedge clock);
        chk("rd_ack", 32'({b1.i_ack, b1.d_ack}), 32'd1);
        chk("rd_data", {b1.i_rdata, b1.d_rdata}, 32'h13ab8001);
        b1.d_req = 1'b0;
        exp_d = 16'h8001;
        @(negedge clock);

        // randomized rounds checked against the reference model
        for (int r = 0; r < 40; r++) begin
            pat = int'($urandom_range(1, 3));
            b1.i_addr = 8'($urandom);
            b1.d_addr = 8'($urandom_range(0, 15));
            b1.d_wdata = 16'($urandom);
            b1.d_we = 1'($urandom_range(0, 1));
            hold = (pat == 3) && ($urandom_range(0, 1) == 1);
            ng = hold ? int'($urandom_range(2, 7)) : ((pat == 3) ? 2 : 1);
            run_round(pat[0], pat[1], hold, ng, ord);
        end

        // continuous contention from a fresh reset
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_i = 16'h0000; exp_d = 16'h0000; starve = 0;
        b1.d_we = 1'b0; b1.d_addr = 8'h10; b1.i_addr = 8'h00;
        run_round(1'b1, 1'b1, 1'b1, 6, ord);
        chk("contention_order", 32'(ord[5:0]), 32'h36);
        repeat (2) @(negedge clock);
`ifdef MEMARB_PERF_EN
        chk("perf_d_grant", 32'(dg1), 32'd4);
        chk("perf_i_grant", 32'(ig1), 32'd2);
        chk("perf_conflict", 32'(cf1), 32'd6);
`endif

        // reset while a read is pending (MEM_LAT=3)
        b3.d_we = 1'b0; b3.d_addr = 8'h20; b3.i_addr = 8'h30;
        b3.i_req = 1'b1; b3.d_req = 1'b1;
        guard = 0;
        do begin @(negedge clock); guard++; end while (!(b3.i_ack || b3.d_ack) && guard < 20);
        chk("r3_first_ack", 32'({b3.i_ack, b3.d_ack}), 32'd1);
        chk("r3_first_data", 32'(b3.d_rdata), 32'hc320);
        guard = 0;
        do begin @(negedge clock); guard++; end while (!b3.m_en && guard < 10);
        chk("r3_second_issue", 32'({b3.m_en, b3.m_addr}), 32'h120);
        @(negedge clock);
        chk("r3_wait_busy", 32'({b3.busy, b3.m_en}), 32'd2);
        rst3 = 1'b1; b3.i_req = 1'b0; b3.d_req = 1'b0;
        @(negedge clock);
        chk("r3_after_reset", 32'({b3.busy, b3.m_en, b3.i_ack, b3.d_ack}), 32'd0);
        chk("r3_rdata_cleared", {b3.i_rdata, b3.d_rdata}, 32'd0);
        rst3 = 1'b0;
        acks = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (b3.i_ack || b3.d_ack || b3.m_en) acks++;
        end
        chk("r3_no_ack", 32'(acks), 32'd0);
        b3.i_req = 1'b1; b3.d_req = 1'b1;
        guard = 0;
        do begin @(negedge clock); guard++; end while (!(b3.i_ack || b3.d_ack) && guard < 20);
        chk("r3_starve_cleared", 32'({b3.i_ack, b3.d_ack}), 32'd1);
        b3.i_req = 1'b0; b3.d_req = 1'b0;
        repeat (3) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
